// File: rtl/adc_capture.sv
// adc_capture: two-stage capture path for a dual-channel 14-bit ADC. Words
// are qualified by the DAC-side sync strobe. After a configurable number of
// qualified words are dropped, samples are emitted with a position-in-period
// index for a fixed number of periods, or without end.
module adc_capture #(
  parameter int unsigned DISCARD   = 4,
  parameter bit          TWOS_COMP = 1'b1
) (
  input  logic        CLK_65,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sync_in,
  input  logic [15:0] ptos_x_ciclo,
  input  logic [15:0] n_ciclos,
  input  logic [13:0] ADC_DA,
  input  logic [13:0] ADC_DB,
  input  logic        ADC_OTR_A,
  input  logic        ADC_OTR_B,
  output logic        ADC_CLK_A,
  output logic        ADC_CLK_B,
  output logic        ADC_OEB_A,
  output logic        ADC_OEB_B,
  output logic [13:0] data_a,
  output logic [13:0] data_b,
  output logic        data_valid,
  output logic [15:0] sample_idx,
  output logic        cycle_start,
  output logic        overrange,
  output logic        done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_SYNC = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // Index of the last word that is dropped while settling.
  localparam logic [15:0] DISC_LAST = (DISCARD > 0) ? 16'(DISCARD - 1) : 16'd0;

  // Offset-binary to two's complement is an MSB flip.
  function automatic logic [13:0] conv(input logic [13:0] d);
    conv = TWOS_COMP ? {~d[13], d[12:0]} : d;
  endfunction

  // The ADC is clocked directly from the capture clock. Its outputs are always enabled.
  assign ADC_CLK_A = CLK_65;
  assign ADC_CLK_B = CLK_65;
  assign ADC_OEB_A = 1'b0;
  assign ADC_OEB_B = 1'b0;

  // Stage 1: pin registers
  logic [13:0] da1_q, db1_q;
  logic        otra1_q, otrb1_q, sync1_q;

  // Control state
  logic [2:0]  state_q, state_d;
  logic [15:0] ptos_q, ptos_d;     // effective period length, never 0 once latched
  logic [15:0] ncyc_q, ncyc_d;
  logic [15:0] idx_q, idx_d;       // index the next emitted sample will carry
  logic [15:0] cyc_q, cyc_d;       // completed periods
  logic [15:0] disc_q, disc_d;     // qualified words dropped so far while settling
  logic        last_q, last_d;     // final sample of the run has been emitted

  // Stage 2: output registers
  logic [13:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic        valid_q, valid_d, cs_q, cs_d, ovr_q, ovr_d;
  logic [15:0] sidx_q, sidx_d;

  // Stage-1 capture runs every cycle, independent of the control state.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      da1_q   <= '0;
      db1_q   <= '0;
      otra1_q <= 1'b0;
      otrb1_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      da1_q   <= ADC_DA;
      db1_q   <= ADC_DB;
      otra1_q <= ADC_OTR_A;
      otrb1_q <= ADC_OTR_B;
      sync1_q <= sync_in;
    end
  end

  // Next-state logic. Emission happens only in CAPTURE on a qualified word.
  always_comb begin
    state_d  = state_q;
    ptos_d   = ptos_q;
    ncyc_d   = ncyc_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    disc_d   = disc_q;
    last_d   = last_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    valid_d  = 1'b0;
    cs_d     = 1'b0;
    ovr_d    = ovr_q;
    sidx_d   = sidx_q;

    if (!enable) begin
      // Drop back to idle. Anything still in flight is not emitted.
      state_d = S_IDLE;
      idx_d   = '0;
      cyc_d   = '0;
      disc_d  = '0;
      last_d  = 1'b0;
      sidx_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_SYNC;
        S_WAIT_SYNC: begin
          if (sync1_q) begin
            ptos_d  = (ptos_x_ciclo == 16'd0) ? 16'd1 : ptos_x_ciclo;
            ncyc_d  = n_ciclos;
            idx_d   = '0;
            cyc_d   = '0;
            disc_d  = '0;
            last_d  = 1'b0;
            ovr_d   = 1'b0;
            sidx_d  = '0;
            state_d = (DISCARD == 0) ? S_CAPTURE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (sync1_q) begin
            if (disc_q == DISC_LAST) begin
              disc_d  = '0;
              state_d = S_CAPTURE;
            end else begin
              disc_d = disc_q + 16'd1;
            end
          end
        end
        S_CAPTURE: begin
          if (last_q) begin
            state_d = S_DONE;
          end else if (sync1_q) begin
            valid_d  = 1'b1;
            sidx_d   = idx_q;
            cs_d     = (idx_q == 16'd0);
            data_a_d = conv(da1_q);
            data_b_d = conv(db1_q);
            if (otra1_q || otrb1_q) ovr_d = 1'b1;
            if (idx_q == ptos_q - 16'd1) begin
              idx_d = '0;
              cyc_d = cyc_q + 16'd1;
              if ((ncyc_q != 16'd0) && (cyc_q == ncyc_q - 16'd1)) last_d = 1'b1;
            end else begin
              idx_d = idx_q + 16'd1;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and stage-2 registers
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptos_q   <= '0;
      ncyc_q   <= '0;
      idx_q    <= '0;
      cyc_q    <= '0;
      disc_q   <= '0;
      last_q   <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      valid_q  <= 1'b0;
      cs_q     <= 1'b0;
      ovr_q    <= 1'b0;
      sidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptos_q   <= ptos_d;
      ncyc_q   <= ncyc_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      disc_q   <= disc_d;
      last_q   <= last_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      valid_q  <= valid_d;
      cs_q     <= cs_d;
      ovr_q    <= ovr_d;
      sidx_q   <= sidx_d;
    end
  end

  assign data_a      = data_a_q;
  assign data_b      = data_b_q;
  assign data_valid  = valid_q;
  assign sample_idx  = sidx_q;
  assign cycle_start = cs_q;
  assign overrange   = ovr_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DISCARD, default 4: sync-qualified samples dropped after each sync acquisition before capture starts.
REQ-002 Parameter TWOS_COMP, default 1: 1 = convert offset-binary ADC codes to two's complement (invert MSB); 0 = pass raw codes.
REQ-003 CLK_65  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = run, 0 = return to IDLE.
REQ-006 sync_in  input  1  sample-qualifier from the DAC side (data_valid_dac_export); 1 = current ADC word is meaningful.
REQ-007 ptos_x_ciclo  input  16  samples per signal period.
REQ-008 n_ciclos  input  16  periods to capture per run; 0 = continuous.
REQ-009 ADC_DA, ADC_DB  input  14 each  parallel ADC data, channels A/B.
REQ-010 ADC_OTR_A, ADC_OTR_B  input  1 each  ADC out-of-range flags.
REQ-011 ADC_CLK_A, ADC_CLK_B  output  1 each  ADC sample clocks, equal to CLK_65.
REQ-012 ADC_OEB_A, ADC_OEB_B  output  1 each  ADC output enables, active-low, constant 0.
REQ-013 data_a, data_b  output  14 each  captured samples (format per TWOS_COMP).
REQ-014 data_valid  output  1  1 for exactly one cycle per emitted sample.
REQ-015 sample_idx  output  16  position of the emitted sample within its period, 0..ptos_x_ciclo-1.
REQ-016 cycle_start  output  1  1 with data_valid when sample_idx = 0.
REQ-017 overrange  output  1  sticky out-of-range flag.
REQ-018 done  output  1  1 while in DONE.

Function
REQ-019 Stage 1 shall register ADC_DA, ADC_DB, both OTR flags and sync_in every cycle, regardless of state.
REQ-020 Stage 2 shall register the converted stage-1 data; pins sampled at edge k appear on data_a/data_b after edge k+1, together with data_valid when emitted (2-cycle latency).
REQ-021 FSM states: IDLE, WAIT_SYNC, SETTLE, CAPTURE, DONE; transitions are evaluated on the stage-1 sync bit (sync1).
REQ-022 IDLE -> WAIT_SYNC when enable = 1.
REQ-023 WAIT_SYNC -> SETTLE on sync1 = 1, or directly to CAPTURE if DISCARD = 0. On this transition: latch ptos_x_ciclo and n_ciclos, clear all counters and overrange.
REQ-024 SETTLE: count cycles with sync1 = 1; after DISCARD such cycles -> CAPTURE. Cycles with sync1 = 0 hold the count. No data_valid is emitted in SETTLE.
REQ-025 CAPTURE: each cycle with sync1 = 1 emits one sample. sample_idx advances 0..P-1 and wraps to 0, P = latched ptos_x_ciclo; a latched value of 0 is treated as 1.
REQ-026 CAPTURE, sync1 = 0: no emission; sample_idx and the period counter hold (gap tolerated).
REQ-027 The period counter increments on each wrap. With n_ciclos != 0, emission of the last sample of period n_ciclos -> DONE in the next cycle. With n_ciclos = 0, capture is endless and the period counter wraps at 16 bits.
REQ-028 DONE: done = 1, no emission, hold until enable = 0.
REQ-029 enable = 0 in any state -> IDLE on the next edge; data_valid and cycle_start are 0 from that edge on; counters clear; in-flight stage-2 samples are discarded.
REQ-030 overrange sets when an emitted sample has either OTR = 1, and clears only per REQ-023 or reset.
REQ-031 Input changes to ptos_x_ciclo/n_ciclos during a run are ignored until the next WAIT_SYNC exit.

Reset
REQ-032 reset_n = 0 shall immediately force: state IDLE, all counters 0, data_a = data_b = 0, data_valid = 0, sample_idx = 0, cycle_start = 0, overrange = 0, done = 0, stage-1 registers = 0.
REQ-033 Reset release mid-operation shall restart from IDLE; no sample from before reset is emitted.

Verification
REQ-034 TWOS_COMP=1, DISCARD=4, ptos=8, n_ciclos=2, sync held 1, ADC_DA ramps from 8192 -> first 4 synced words dropped; 16 data_valid pulses; cycle_start on samples 0 and 8; data_a first = 0x0004 (8196 with MSB inverted); done rises one cycle after the 16th sample.
REQ-035 Same setup, sync_in low for 3 cycles mid-period at sample_idx = 5 -> 3-cycle data_valid gap, next sample_idx = 6, total still 16 samples.
REQ-036 ADC_OTR_B = 1 for one cycle during SETTLE -> overrange stays 0; ADC_OTR_B = 1 during CAPTURE -> overrange = 1 until the next run's sync.
REQ-037 enable dropped at sample_idx = 3 -> data_valid = 0 from the next edge, state IDLE; re-enable restarts with the DISCARD drop and sample_idx = 0.
REQ-038 Asynchronous reset pulse between clock edges during CAPTURE -> all outputs 0 before the next edge.
REQ-039 TWOS_COMP=0, ptos=0, n_ciclos=0 -> raw codes passed unchanged, cycle_start with every sample, capture never reaches DONE.
